// File: rtl/pipe_scheduler_if.sv
// Handshake bundle between control/display and the pipe scheduler.
// master drives the game-state inputs and slave owns the slot words.
interface pipe_scheduler_if;
   logic        tick;
   logic        run;
   logic        freeze;
   logic        mode;
   logic [31:0] pipe1;
   logic [31:0] pipe2;
   logic [31:0] pipe3;
   logic [1:0]  pass;
   logic        busy;

   modport master (output tick, run, freeze, mode,
                   input  pipe1, pipe2, pipe3, pass, busy);
   modport slave  (input  tick, run, freeze, mode,
                   output pipe1, pipe2, pipe3, pass, busy);
endinterface

// File: rtl/pipe_scheduler.sv
// Three-slot pipe scheduler: per frame tick it scrolls, retires/scores, then spawns.
// Slot word = {valid, scored, x[10:0] signed, gap_top[8:0], gap_bottom[9:0]}.
module pipe_scheduler #(
   parameter int SCREEN_W   = 640,
   parameter int PIPE_W     = 52,
   parameter int BIRD_X     = 160,
   parameter int SPACING    = 220,
   parameter int Y_MIN      = 40,
   parameter int GAP_EASY   = 120,
   parameter int GAP_HARD   = 90,
   parameter int SPEED_EASY = 2,
   parameter int SPEED_HARD = 4
) (
   input logic             clk,
   input logic             rst,
   pipe_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WAIT, MOVE, CHECK, SPAWN} state_t;

   localparam logic signed [10:0] L_PIPE_W   = 11'(PIPE_W);
   localparam logic signed [10:0] L_BIRD_X   = 11'(BIRD_X);
   localparam logic        [10:0] L_SCREEN_W = 11'(SCREEN_W);
   localparam logic        [9:0]  L_SPACING  = 10'(SPACING);

   state_t      r_state, w_next;
   logic [31:0] r_slot [3];
   logic [31:0] w_slot [3];
   logic [7:0]  r_lfsr;
   logic [9:0]  r_dist, w_dist;
   logic [1:0]  r_cnt, w_cnt, r_pass, w_pass;
   logic [10:0] w_spd, w_dsum;
   logic [9:0]  w_gap, w_gbot;
   logic [8:0]  w_gtop;
   logic        w_found;

   assign w_spd  = bus.mode ? 11'(SPEED_HARD) : 11'(SPEED_EASY);
   assign w_gap  = bus.mode ? 10'(GAP_HARD) : 10'(GAP_EASY);
   assign w_gtop = 9'(Y_MIN) + {1'b0, r_lfsr};
   assign w_gbot = {1'b0, w_gtop} + w_gap;
   assign w_dsum = {1'b0, r_dist} + w_spd;

   always_comb begin
      w_next  = r_state;
      w_slot  = r_slot;
      w_dist  = r_dist;
      w_cnt   = r_cnt;
      w_pass  = 2'd0;
      w_found = 1'b0;
      unique case (r_state)
         IDLE:  w_next = WAIT;
         WAIT:  if (bus.tick && !bus.freeze) w_next = MOVE;
         MOVE: begin
            for (int i = 0; i < 3; i++)
               if (r_slot[i][31]) w_slot[i][29:19] = r_slot[i][29:19] - w_spd;
            w_dist = (w_dsum > 11'd1023) ? 10'd1023 : w_dsum[9:0];
            w_next = CHECK;
         end
         CHECK: begin
            w_cnt = 2'd0;
            for (int i = 0; i < 3; i++) begin
               if (r_slot[i][31]) begin
                  if ($signed(r_slot[i][29:19]) <= -L_PIPE_W)
                     w_slot[i] = '0;
                  else if (!r_slot[i][30] && ($signed(r_slot[i][29:19]) + L_PIPE_W < L_BIRD_X)) begin
                     w_slot[i][30] = 1'b1;
                     w_cnt = w_cnt + 2'd1;
                  end
               end
            end
            w_next = SPAWN;
         end
         SPAWN: begin
            // Lowest free slot wins; with no free slot the spawn is deferred and dist keeps growing.
            if (r_dist >= L_SPACING) begin
               for (int i = 0; i < 3; i++) begin
                  if (!w_found && !r_slot[i][31]) begin
                     w_found   = 1'b1;
                     w_slot[i] = {1'b1, 1'b0, L_SCREEN_W, w_gtop, w_gbot};
                  end
               end
               if (w_found) w_dist = '0;
            end
            w_pass = r_cnt;
            w_next = WAIT;
         end
         default: w_next = IDLE;
      endcase
      if (!bus.run) begin
         w_next = IDLE;
         w_dist = L_SPACING;
         w_pass = 2'd0;
         for (int i = 0; i < 3; i++) w_slot[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_lfsr  <= 8'hA5;
         r_dist  <= L_SPACING;
         r_cnt   <= 2'd0;
         r_pass  <= 2'd0;
         for (int i = 0; i < 3; i++) r_slot[i] <= '0;
      end else begin
         r_state <= w_next;
         r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_dist  <= w_dist;
         r_cnt   <= w_cnt;
         r_pass  <= w_pass;
         for (int i = 0; i < 3; i++) r_slot[i] <= w_slot[i];
      end
   end

   assign bus.pipe1 = r_slot[0];
   assign bus.pipe2 = r_slot[1];
   assign bus.pipe3 = r_slot[2];
   assign bus.pass  = r_pass;
   assign bus.busy  = (r_state == MOVE) || (r_state == CHECK) || (r_state == SPAWN);
endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Owns the three pipe slots consumed by `display` (`pipe_1..pipe_3`) and replaces the pipe bookkeeping inside `control`. On each frame tick it runs a three-step sequence over the slots:
- scroll every pipe left;
- retire pipes that have left the screen and score pipes the bird has cleared;
- spawn a new pipe into a free slot at a fixed horizontal spacing, with an LFSR-randomised gap.

It sits between `control` (game state, frame tick, difficulty) and `display`.

## Interface
Parameters:
- SCREEN_W, 640, spawn x position (left edge of a new pipe)
- PIPE_W, 52, pipe width in pixels
- BIRD_X, 160, bird left x used for pass detection
- SPACING, 220, pixels scrolled between spawns
- Y_MIN, 40, minimum gap_top
- GAP_EASY, 120, gap height when mode=0
- GAP_HARD, 90, gap height when mode=1
- SPEED_EASY, 2, pixels per tick when mode=0
- SPEED_HARD, 4, pixels per tick when mode=1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- tick  in  1  frame pulse, one cycle wide
- run  in  1  game in play; low clears all slots
- freeze  in  1  game over; holds the slots
- mode  in  1  difficulty select (0 easy, 1 hard)
- pipe1, pipe2, pipe3  out  32 each  slot words
- pass  out  2  number of pipes scored this sequence; valid for one cycle
- busy  out  1  sequence in progress

Slot word layout:
- [31] valid
- [30] scored
- [29:19] x, 11-bit two's complement, left edge
- [18:10] gap_top, 9 bits
- [9:0] gap_bottom, 10 bits

## Operation
- FSM states: IDLE, WAIT, MOVE, CHECK, SPAWN.
- Priority: rst low > run low > freeze.
- rst low: FSM goes to IDLE; all slot words and pass are 0; busy is 0; LFSR = 8'hA5; dist = SPACING.
- run low in any state:
  - next cycle the FSM is in IDLE and all slots are cleared to 0;
  - dist = SPACING, so the first spawn happens on the first tick after run rises.
- IDLE -> WAIT when run is high.
- WAIT -> MOVE when tick is high and freeze is low.
  - tick is ignored outside WAIT.
  - freeze is sampled only in WAIT; a sequence already in flight completes.
- MOVE: for every valid slot, x -= speed, where speed comes from the current mode. dist = min(dist + speed, 1023).
- CHECK, per valid slot:
  - if x <= -PIPE_W (signed), clear the whole word to 0 (retire);
  - else if scored=0 and x + PIPE_W < BIRD_X (signed), set scored=1 and count the slot into pass.
  - pass drives this count for exactly one cycle (the cycle in SPAWN); otherwise pass is 0.
- SPAWN:
  - if dist >= SPACING and at least one slot is invalid: fill the lowest-index invalid slot with valid=1, scored=0, x=SCREEN_W, gap_top=Y_MIN+lfsr, gap_bottom=gap_top+gap (gap from current mode); then set dist=0.
  - otherwise make no change; the spawn is deferred and dist keeps growing (saturating).
  - SPAWN -> WAIT.
- A slot retired in CHECK is available to SPAWN in the same sequence.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle when rst is high.
- Arithmetic:
  - gap_top range is 40..295, which fits in 9 bits;
  - gap_bottom is at most 415;
  - x compares are signed 11-bit, with PIPE_W and BIRD_X zero-extended to 11 bits.
- A mode change takes effect at the next MOVE (speed) and the next SPAWN (gap). Existing pipes keep their gap.

## Timing
- Tick sampled in WAIT at cycle T:
  - MOVE at T+1, CHECK at T+2, SPAWN at T+3;
  - moved x is visible on the outputs at T+2;
  - retire and scored updates are visible at T+3;
  - spawned slot and pass are visible at T+4.
- busy is high from T+1 through T+3.
- Ticks must be at least 4 cycles apart. A tick arriving while busy is dropped.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset and start:
  - rst low -> all slot words 0, pass 0, busy 0.
  - Release, run=1, mode=0, first tick -> pipe1 valid with x=640, gap_bottom-gap_top=120, pipe2 and pipe3 stay 0.
- Scroll and pass:
  - mode=0, ticks continue.
  - Second tick -> pipe1 x=638.
  - Tick 268 -> pipe1 x=106, scored=1, pass=1 for exactly one cycle; no further pass from pipe1.
- Spawn cadence and deferral (mode=0):
  - spawns land in slots 1/2/3 at ticks 1/111/221;
  - at tick 331 dist=220 but no slot is free -> no spawn;
  - tick 347 -> pipe1 retires in CHECK and a new pipe at x=640 is spawned into slot 1 in the same sequence; dist returns to 0.
- Freeze:
  - freeze=1 in WAIT, 10 ticks -> slots unchanged, busy stays 0.
  - freeze=0 -> scrolling resumes on the next tick.
- Run drop mid-sequence:
  - run=0 during CHECK -> next cycle the FSM is in IDLE and all slots are 0.
  - run=1 then tick -> immediate spawn at x=640.
- Mode switch:
  - with pipe1 at x=600 and mode=1, the next tick -> x=596;
  - the next spawned pipe has gap 90;
  - an existing pipe keeps gap 120.
